// File: rtl/rr_mux_arbiter.sv
// Eight-requester round-robin arbiter driving a shared 8:1 lane selector.
// Each grant delivers at most MAX_HOLD registered beats before re-arbitration.
module rr_mux_arbiter #(
  parameter int unsigned W        = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     req,
  input  logic [8*W-1:0] din,
  output logic [7:0]     gnt,
  output logic [2:0]     sel,
  output logic           busy,
  output logic [W-1:0]   dout,
  output logic           dout_valid
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  logic [7:0]      r_gnt;
  logic [2:0]      r_sel;
  logic            r_busy;
  logic [W-1:0]    r_dout;
  logic            r_dout_valid;
  logic [2:0]      r_ptr;
  logic [CW-1:0]   r_cnt;

  state_t          w_state_nxt;
  logic [7:0]      w_gnt_nxt;
  logic [2:0]      w_sel_nxt;
  logic [W-1:0]    w_dout_nxt;
  logic            w_valid_nxt;
  logic [2:0]      w_ptr_nxt;
  logic [CW-1:0]   w_cnt_nxt;

  logic            w_found;
  logic [2:0]      w_pick;
  logic [2:0]      w_idx;
  logic [W-1:0]    w_lane;

  // Search from ptr upward; scanning backwards lets the closest requester win.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_idx   = r_ptr;
    for (int k = 7; k >= 0; k--) begin
      w_idx = r_ptr + 3'(k);
      if (req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_lane = din[r_sel*W +: W];

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_dout_nxt  = r_dout;
    w_valid_nxt = r_dout_valid;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_valid_nxt = 1'b0;
        w_gnt_nxt   = 8'h00;
        if (w_found) begin
          w_sel_nxt   = w_pick;
          w_gnt_nxt   = 8'h01 << w_pick;
          w_cnt_nxt   = '0;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!req[r_sel]) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = 8'h00;
          w_valid_nxt = 1'b0;
          w_ptr_nxt   = r_sel + 3'd1;
        end else begin
          w_dout_nxt  = w_lane;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = r_cnt + 8'd1;
          if (r_cnt == HOLD_LAST) begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = 8'h00;
            w_ptr_nxt   = r_sel + 3'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_gnt        <= 8'h00;
      r_sel        <= 3'd0;
      r_busy       <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_ptr        <= 3'd0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_gnt        <= w_gnt_nxt;
      r_sel        <= w_sel_nxt;
      r_busy       <= (w_state_nxt == S_BUSY);
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_valid_nxt;
      r_ptr        <= w_ptr_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  assign gnt        = r_gnt;
  assign sel        = r_sel;
  assign busy       = r_busy;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Randomized and directed bench for rr_mux_arbiter against a transaction-level
// model that tracks the current owner, beats delivered and rotation pointer.
module tb_rr_mux_arbiter;

  localparam int unsigned W        = 4;
  localparam int unsigned MAX_HOLD = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [7:0]     req;
  logic [8*W-1:0] din;
  logic [7:0]     gnt;
  logic [2:0]     sel;
  logic           busy;
  logic [W-1:0]   dout;
  logic           dout_valid;

  rr_mux_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset), .req(req), .din(din),
    .gnt(gnt), .sel(sel), .busy(busy), .dout(dout), .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: owner is -1 when nobody holds the grant.
  int           m_owner = -1;
  int           m_ptr   = 0;
  int           m_beats = 0;
  int           m_sel   = 0;
  logic [W-1:0] m_dout  = '0;
  logic         m_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_beats = 0; m_sel = 0; m_dout = '0; m_valid = 1'b0;
    end else if (m_owner < 0) begin
      m_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
        int i;
        i = (m_ptr + k) % 8;
        if (req[i]) begin
          m_owner = i; m_sel = i; m_beats = 0;
          break;
        end
      end
    end else if (!req[m_owner]) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
      m_valid = 1'b0;
    end else begin
      m_dout  = din[m_owner*W +: W];
      m_valid = 1'b1;
      m_beats++;
      if (m_beats == MAX_HOLD) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end
    end
  endtask

  // Advance one edge, update the model with the inputs seen there, compare.
  task automatic tick();
    logic [7:0] exp_gnt;
    @(posedge clk);
    #1;
    model_step();
    exp_gnt = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    chk("gnt", gnt, exp_gnt);
    chk("sel", sel, 32'(m_sel));
    chk("busy", busy, (m_owner >= 0) ? 1 : 0);
    chk("dout_valid", dout_valid, m_valid);
    if (m_valid) chk("dout", dout, m_dout);
    chk("gnt_onehot0", $onehot0(gnt), 1);
    if (busy) chk("gnt_at_sel", gnt[sel], 1);
  endtask

  task automatic lanes_index();
    for (int i = 0; i < 8; i++) din[i*W +: W] = W'(i);
  endtask

  initial begin
    reset = 1'b1;
    req   = 8'hFF;
    din   = '0;

    // Reset held with all requests active, then first grant goes to lane 0
    tick(); tick();
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_sel", sel, 0);
    reset = 1'b0;
    tick();
    chk("first_gnt_lane0", gnt, 8'h01);

    // Single requester on lane 3 carrying a 1
    reset = 1'b1; tick(); reset = 1'b0;
    din = '0; din[3*W +: W] = W'(1);
    req = 8'h08;
    tick(); chk("single_e1_gnt", gnt, 8'h08); chk("single_e1_sel", sel, 3);
    for (int e = 2; e <= 5; e++) begin
      tick(); chk("single_beat", {dout_valid, dout}, {1'b1, W'(1)});
    end
    chk("single_e5_busy", busy, 0);
    tick(); chk("single_e6_regrant", gnt, 8'h08);

    // Round robin between lanes 0 and 7, wrapping the pointer
    reset = 1'b1; tick(); reset = 1'b0;
    lanes_index();
    req = 8'h81;
    for (int c = 0; c < 25; c++) tick();

    // Early withdraw on lane 2 while lane 5 waits
    reset = 1'b1; tick(); reset = 1'b0;
    req = 8'h24;
    tick(); chk("wd_gnt2", gnt, 8'h04);
    tick(); tick();
    req = 8'h20;
    tick(); chk("wd_busy0", busy, 0); chk("wd_no_beat", dout_valid, 0);
    tick(); chk("wd_gnt5", gnt, 8'h20);
    tick();

    // Reset during the second beat of lane 6
    reset = 1'b1; tick(); reset = 1'b0;
    req = 8'h40;
    tick(); tick();
    reset = 1'b1; req = 8'h41;
    tick(); chk("mid_rst_gnt", gnt, 8'h00); chk("mid_rst_valid", dout_valid, 0);
    reset = 1'b0;
    tick(); chk("mid_rst_lane0", gnt, 8'h01);

    // Lane routing: each single lane in turn carries its own index
    lanes_index();
    for (int i = 0; i < 8; i++) begin
      req = 8'h01 << i;
      for (int c = 0; c < 7; c++) tick();
    end

    // Random traffic with sticky requests, changing data and rare resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3, 0) == 0) req = 8'($urandom);
      din   = (8*W)'({$urandom, $urandom});
      reset = ($urandom_range(99, 0) == 0);
      tick();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
